fpalu_wb: RTL



---
 rtl/fpalu_wb_if.sv | 31 +++
 rtl/fpalu_wb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fpalu_wb_if.sv
// fpalu_wb_if -- result stream from the unified FP pipeline into the
// FP16 write-back block.
//   in_valid   producer has a result on the bus
//   in_ready   consumer accepts the result this cycle (valid & ready)
//   in_sgn     sign
//   in_exp     6-bit exponent, bias 15
//   in_man_dn  22-bit mantissa, bit 21 hidden bit, bits 20:0 fraction
// Modports: master = result producer, slave = write-back block.
interface fpalu_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sgn;
  logic [5:0]  in_exp;
  logic [21:0] in_man_dn;

  modport master (
    output in_valid,
    output in_sgn,
    output in_exp,
    output in_man_dn,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sgn,
    input  in_exp,
    input  in_man_dn,
    output in_ready
  );
endinterface

// File: rtl/fpalu_wb.sv
// fpalu_wb -- converts a job of unified FP results to FP16 (round to
// nearest even, overflow forced to infinity) and writes them to
// consecutive addresses of a result RAM.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      single-cycle job start pulse (honoured only when idle)
//   base_addr  first write address of the job
//   count      results in the job, 0 means 2^AW
//   in_bus     result stream (slave side of fpalu_wb_if)
//   mem_we     result RAM write enable
//   mem_addr   result RAM address
//   mem_wdata  FP16 result
//   busy       high whenever the block is not idle
//   done       one-cycle pulse at job end
//   ovf_cnt    saturating count of results forced to infinity this job
module fpalu_wb #(
  parameter int AW    = 9,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    count,
  fpalu_wb_if.slave        in_bus,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [OVF_W-1:0] OVF_MAX  = {OVF_W{1'b1}};
  localparam logic [AW:0]      REM_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  // One bit wider than count so that a count of 0 can hold 2^AW.
  logic [AW:0]      remaining_r;
  logic [AW-1:0]    ptr_r;
  logic             accept_s;
  logic             ovf_s;
  logic [15:0]      conv_s;
  // The hidden bit does not enter the packed encoding.
  logic             unused_hidden_s;

  // FP16 packing: the exponent and top fraction bits are concatenated so
  // that a rounding carry out of the fraction ripples into the exponent
  // (denormal -> normal, exponent increment). Returns {overflow, fp16}.
  function automatic logic [16:0] to_fp16(
    input logic        sgn,
    input logic [5:0]  exp,
    input logic [20:0] frac
  );
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        rnd;
    logic [14:0] p;
    logic        ovf;
    guard  = frac[10];
    sticky = |frac[9:0];
    lsb    = frac[11];
    rnd    = guard & (sticky | lsb);
    p      = {exp[4:0], frac[20:11]} + {14'd0, rnd};
    ovf    = (exp >= 6'd31) || (p[14:10] == 5'h1F);
    if (ovf) begin
      return {1'b1, sgn, 5'h1F, 10'h000};
    end else begin
      return {1'b0, sgn, p};
    end
  endfunction

  assign unused_hidden_s = in_bus.in_man_dn[21];

  // Ready is decoded from registered state only, never from in_valid.
  assign in_bus.in_ready = (state_r == RUN) && (remaining_r != REM_ZERO);
  assign accept_s        = in_bus.in_valid & in_bus.in_ready;
  assign busy            = (state_r != IDLE);
  assign done            = (state_r == DONE);

  // Conversion of the beat currently on the bus.
  always_comb begin
    {ovf_s, conv_s} = to_fp16(in_bus.in_sgn, in_bus.in_exp, in_bus.in_man_dn[20:0]);
  end

  // Next-state decode for the job sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // The beat that empties the counter still has its write pending.
        if (accept_s && (remaining_r == REM_ONE)) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Job bookkeeping, overflow counter and registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_r <= REM_ZERO;
      ptr_r       <= {AW{1'b0}};
      ovf_cnt     <= {OVF_W{1'b0}};
      mem_we      <= 1'b0;
      mem_addr    <= {AW{1'b0}};
      mem_wdata   <= 16'h0000;
    end else begin
      mem_we <= accept_s;
      if ((state_r == IDLE) && start) begin
        ptr_r       <= base_addr;
        remaining_r <= {(count == {AW{1'b0}}), count};
        ovf_cnt     <= {OVF_W{1'b0}};
      end else if (accept_s) begin
        mem_addr    <= ptr_r;
        mem_wdata   <= conv_s;
        ptr_r       <= ptr_r + PTR_ONE;
        remaining_r <= remaining_r - REM_ONE;
        if (ovf_s && (ovf_cnt != OVF_MAX)) begin
          ovf_cnt <= ovf_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
